// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the two-requester memory arbiter: FSM states, grant
// identities and the bank field decoded from address bits [14:13].
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESPOND = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_CPU = 1'b0,
        GRANT_DMA = 1'b1
    } grant_e;

    localparam logic [1:0] BANK_RAM    = 2'b00;
    localparam logic [1:0] BANK_ROM    = 2'b01;
    localparam logic [1:0] BANK_PERIPH = 2'b10;
    localparam logic [1:0] BANK_BRAM   = 2'b11;

    function automatic logic is_rom_bank(input logic [1:0] bank);
        return bank == BANK_ROM;
    endfunction

endpackage

// File: rtl/memory_arbiter_pick.sv
// Combinational grant selection. MEMORY_ARBITER_ROUND_ROBIN_EN selects
// alternating priority on contested requests; otherwise the CPU always wins.
module arbiter_pick
    import memory_arbiter_pkg::*;
(
    input  logic cpu_request,
    input  logic dma_request,
    input  logic last_grant,
    output logic grant,
    output logic any
);

    always_comb begin
        any   = cpu_request | dma_request;
        // With no request the grant is a don't-care; holding last_grant keeps it stable.
        grant = last_grant;
        if (cpu_request && dma_request) begin
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            grant = (last_grant == GRANT_CPU) ? GRANT_DMA : GRANT_CPU;
`else
            grant = GRANT_CPU;
`endif
        end else if (cpu_request) begin
            grant = GRANT_CPU;
        end else if (dma_request) begin
            grant = GRANT_DMA;
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// CPU/DMA arbiter in front of memory_bus: IDLE -> ACCESS -> RESPOND per access,
// ROM-bank writes suppressed and flagged. Priority set by MEMORY_ARBITER_ROUND_ROBIN_EN.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_request,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_address,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  dma_request,
    input  logic                  dma_write,
    input  logic [ADDR_WIDTH-1:0] dma_address,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_ready,
    output logic                  rom_write_error,
    output logic [ADDR_WIDTH-1:0] bus_address,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_enable,
    output logic                  bus_write_enable
);

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  grant_q, grant_d;
    logic                  write_q, write_d;
    logic [ADDR_WIDTH-1:0] bus_address_q, bus_address_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic                  bus_enable_q, bus_enable_d;
    logic                  bus_we_q, bus_we_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] dma_rdata_q, dma_rdata_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic                  dma_ready_q, dma_ready_d;
    logic                  rom_err_q, rom_err_d;

    logic                  pick_grant;
    logic                  pick_any;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_wdata;

    arbiter_pick u_pick (
        .cpu_request (cpu_request),
        .dma_request (dma_request),
        .last_grant  (last_grant_q),
        .grant       (pick_grant),
        .any         (pick_any)
    );

    assign sel_write   = (pick_grant == GRANT_DMA) ? dma_write   : cpu_write;
    assign sel_address = (pick_grant == GRANT_DMA) ? dma_address : cpu_address;
    assign sel_wdata   = (pick_grant == GRANT_DMA) ? dma_wdata   : cpu_wdata;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        write_d       = write_q;
        bus_address_d = bus_address_q;
        bus_wdata_d   = bus_wdata_q;
        cpu_rdata_d   = cpu_rdata_q;
        dma_rdata_d   = dma_rdata_q;
        bus_enable_d  = 1'b0;
        bus_we_d      = 1'b0;
        cpu_ready_d   = 1'b0;
        dma_ready_d   = 1'b0;
        rom_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d       = ACCESS;
                    grant_d       = pick_grant;
                    last_grant_d  = pick_grant;
                    write_d       = sel_write;
                    bus_address_d = sel_address;
                    bus_wdata_d   = sel_wdata;
                    bus_enable_d  = 1'b1;
                    bus_we_d      = sel_write && !is_rom_bank(sel_address[14:13]);
                end
            end
            ACCESS: begin
                state_d = RESPOND;
                if (grant_q == GRANT_DMA) begin
                    dma_rdata_d = bus_rdata;
                    dma_ready_d = 1'b1;
                end else begin
                    cpu_rdata_d = bus_rdata;
                    cpu_ready_d = 1'b1;
                end
                // The bus cycle of a dropped ROM write still ran; only the strobe was withheld.
                rom_err_d = write_q && is_rom_bank(bus_address_q[14:13]);
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= GRANT_DMA;
            grant_q       <= GRANT_CPU;
            write_q       <= 1'b0;
            bus_address_q <= '0;
            bus_wdata_q   <= '0;
            bus_enable_q  <= 1'b0;
            bus_we_q      <= 1'b0;
            cpu_rdata_q   <= '0;
            dma_rdata_q   <= '0;
            cpu_ready_q   <= 1'b0;
            dma_ready_q   <= 1'b0;
            rom_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            write_q       <= write_d;
            bus_address_q <= bus_address_d;
            bus_wdata_q   <= bus_wdata_d;
            bus_enable_q  <= bus_enable_d;
            bus_we_q      <= bus_we_d;
            cpu_rdata_q   <= cpu_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
            cpu_ready_q   <= cpu_ready_d;
            dma_ready_q   <= dma_ready_d;
            rom_err_q     <= rom_err_d;
        end
    end

    assign cpu_rdata        = cpu_rdata_q;
    assign cpu_ready        = cpu_ready_q;
    assign dma_rdata        = dma_rdata_q;
    assign dma_ready        = dma_ready_q;
    assign rom_write_error  = rom_err_q;
    assign bus_address      = bus_address_q;
    assign bus_wdata        = bus_wdata_q;
    assign bus_enable       = bus_enable_q;
    assign bus_write_enable = bus_we_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a timeline model.
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_request, cpu_write;
    logic [15:0] cpu_address, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        dma_request, dma_write;
    logic [15:0] dma_address, dma_wdata, dma_rdata;
    logic        dma_ready;
    logic        rom_write_error;
    logic [15:0] bus_address, bus_wdata, bus_rdata;
    logic        bus_enable, bus_write_enable;

    memory_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_request      (cpu_request),
        .cpu_write        (cpu_write),
        .cpu_address      (cpu_address),
        .cpu_wdata        (cpu_wdata),
        .cpu_rdata        (cpu_rdata),
        .cpu_ready        (cpu_ready),
        .dma_request      (dma_request),
        .dma_write        (dma_write),
        .dma_address      (dma_address),
        .dma_wdata        (dma_wdata),
        .dma_rdata        (dma_rdata),
        .dma_ready        (dma_ready),
        .rom_write_error  (rom_write_error),
        .bus_address      (bus_address),
        .bus_wdata        (bus_wdata),
        .bus_rdata        (bus_rdata),
        .bus_enable       (bus_enable),
        .bus_write_enable (bus_write_enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Winner of an IDLE-cycle decision (0 = CPU, 1 = DMA).
    function automatic logic tb_pick(input logic c, input logic d, input logic last);
        if (c && !d) return 1'b0;
        if (d && !c) return 1'b1;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        return ~last;
`else
        return 1'b0;
`endif
    endfunction

    // Timeline model: a grant decided in cycle k occupies cycle k+1 (bus)
    // and k+2 (response); the next decision can be taken in cycle k+3.
    initial begin : model
        int          k;
        int          free_c;
        int          acc_c;
        logic        m_valid;
        logic        m_last;
        logic        t_who, t_write;
        logic [15:0] t_addr, t_wdata;
        logic        e_en, e_we, e_crdy, e_drdy, e_rom;
        logic [15:0] e_addr, e_wdata, e_crd, e_drd;
        k = 0; free_c = 0; acc_c = -100; m_valid = 1'b0; m_last = 1'b1;
        t_who = 1'b0; t_write = 1'b0; t_addr = '0; t_wdata = '0;
        e_en = 0; e_we = 0; e_crdy = 0; e_drdy = 0; e_rom = 0;
        e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
        forever begin
            @(negedge clk);
            k++;
            if (m_valid) begin
                chk1 ("m_bus_enable", bus_enable, e_en);
                chk1 ("m_bus_write_enable", bus_write_enable, e_we);
                chk16("m_bus_address", bus_address, e_addr);
                chk16("m_bus_wdata", bus_wdata, e_wdata);
                chk1 ("m_cpu_ready", cpu_ready, e_crdy);
                chk1 ("m_dma_ready", dma_ready, e_drdy);
                chk16("m_cpu_rdata", cpu_rdata, e_crd);
                chk16("m_dma_rdata", dma_rdata, e_drd);
                chk1 ("m_rom_write_error", rom_write_error, e_rom);
            end
            if (reset) begin
                m_valid = 1'b1;
                e_en = 0; e_we = 0; e_crdy = 0; e_drdy = 0; e_rom = 0;
                e_addr = '0; e_wdata = '0; e_crd = '0; e_drd = '0;
                free_c = k + 1;
                acc_c = -100;
                m_last = 1'b1;
            end else if (m_valid) begin
                e_en = 0; e_we = 0; e_crdy = 0; e_drdy = 0; e_rom = 0;
                if (k == acc_c) begin
                    if (t_who) begin e_drdy = 1; e_drd = bus_rdata; end
                    else       begin e_crdy = 1; e_crd = bus_rdata; end
                    e_rom = t_write && (t_addr[14:13] == 2'b01);
                end
                if (k >= free_c && (cpu_request || dma_request)) begin
                    t_who   = tb_pick(cpu_request, dma_request, m_last);
                    m_last  = t_who;
                    t_write = t_who ? dma_write   : cpu_write;
                    t_addr  = t_who ? dma_address : cpu_address;
                    t_wdata = t_who ? dma_wdata   : cpu_wdata;
                    acc_c   = k + 1;
                    free_c  = k + 3;
                    e_en    = 1;
                    e_we    = t_write && (t_addr[14:13] != 2'b01);
                    e_addr  = t_addr;
                    e_wdata = t_wdata;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        logic        got [4];
        logic        exp_seq [4];
        logic        dma_seen;
        logic        cs, ds;
        logic        cpu_busy, dma_busy;
        int          n, guard, cpu_wait, dma_wait;

        reset = 1'b1;
        cpu_request = 0; cpu_write = 0; cpu_address = '0; cpu_wdata = '0;
        dma_request = 0; dma_write = 0; dma_address = '0; dma_wdata = '0;
        bus_rdata = '0;
        repeat (3) tick();
        chk1 ("reset_bus_enable", bus_enable, 1'b0);
        chk1 ("reset_cpu_ready", cpu_ready, 1'b0);
        chk1 ("reset_dma_ready", dma_ready, 1'b0);
        chk16("reset_bus_address", bus_address, 16'h0000);
        reset = 1'b0;
        tick();

        // CPU read of 0x0004 returning 0x1234
        cpu_request = 1; cpu_write = 0; cpu_address = 16'h0004; bus_rdata = 16'h1234;
        tick();
        chk1 ("rd_bus_enable", bus_enable, 1'b1);
        chk16("rd_bus_address", bus_address, 16'h0004);
        chk1 ("rd_early_ready", cpu_ready, 1'b0);
        tick();
        chk1 ("rd_cpu_ready", cpu_ready, 1'b1);
        chk16("rd_cpu_rdata", cpu_rdata, 16'h1234);
        chk1 ("rd_dma_ready", dma_ready, 1'b0);
        chk1 ("rd_bus_enable_off", bus_enable, 1'b0);
        cpu_request = 0;
        tick();
        chk1 ("rd_ready_pulse", cpu_ready, 1'b0);

        // DMA write 0x6002 <- 0xBEEF
        dma_request = 1; dma_write = 1; dma_address = 16'h6002; dma_wdata = 16'hBEEF;
        tick();
        chk1 ("wr_bus_we", bus_write_enable, 1'b1);
        chk16("wr_bus_address", bus_address, 16'h6002);
        chk16("wr_bus_wdata", bus_wdata, 16'hBEEF);
        chk1 ("wr_early_ready", dma_ready, 1'b0);
        tick();
        chk1 ("wr_bus_we_off", bus_write_enable, 1'b0);
        chk1 ("wr_dma_ready", dma_ready, 1'b1);
        dma_request = 0;
        tick();

        // CPU write to ROM bank (0x2010)
        cpu_request = 1; cpu_write = 1; cpu_address = 16'h2010; cpu_wdata = 16'hAAAA;
        tick();
        chk1 ("rom_bus_enable", bus_enable, 1'b1);
        chk1 ("rom_bus_we", bus_write_enable, 1'b0);
        tick();
        chk1 ("rom_error", rom_write_error, 1'b1);
        chk1 ("rom_cpu_ready", cpu_ready, 1'b1);
        chk1 ("rom_bus_we_resp", bus_write_enable, 1'b0);
        cpu_request = 0;
        tick();
        chk1 ("rom_error_pulse", rom_write_error, 1'b0);

        // Contested requests from a fresh reset
        reset = 1; tick(); reset = 0;
        cpu_request = 1; cpu_write = 0; cpu_address = 16'h0100;
        dma_request = 1; dma_write = 0; dma_address = 16'h0200;
        n = 0; guard = 0; dma_seen = 0;
        for (int i = 0; i < 4; i++) got[i] = 1'bx;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
        exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
        while (n < 4 && guard < 40) begin
            tick();
            guard++;
            dma_seen = dma_seen | dma_ready;
            if (cpu_ready && dma_ready) begin
                checks++; errors++;
                $display("FAIL contest_double_ready actual=2 readies required=1");
            end
            if (cpu_ready)      begin got[n] = 1'b0; n++; end
            else if (dma_ready) begin got[n] = 1'b1; n++; end
        end
        chk16("contest_count", 16'(n), 16'd4);
        for (int i = 0; i < 4; i++) chk1("contest_grant", got[i], exp_seq[i]);
`ifndef MEMORY_ARBITER_ROUND_ROBIN_EN
        chk1 ("contest_dma_starved", dma_seen, 1'b0);
`endif
        cpu_request = 0; dma_request = 0;
        repeat (3) tick();

        // Reset during ACCESS of a write
        dma_request = 1; dma_write = 1; dma_address = 16'h0100; dma_wdata = 16'h5555;
        tick();
        chk1 ("abort_we_before", bus_write_enable, 1'b1);
        reset = 1; dma_request = 0;
        tick();
        chk1 ("abort_bus_enable", bus_enable, 1'b0);
        chk1 ("abort_bus_we", bus_write_enable, 1'b0);
        chk1 ("abort_cpu_ready", cpu_ready, 1'b0);
        chk1 ("abort_dma_ready", dma_ready, 1'b0);
        chk1 ("abort_rom_error", rom_write_error, 1'b0);
        chk16("abort_bus_address", bus_address, 16'h0000);
        chk16("abort_bus_wdata", bus_wdata, 16'h0000);
        chk16("abort_cpu_rdata", cpu_rdata, 16'h0000);
        reset = 0;
        repeat (4) begin
            tick();
            chk1("abort_no_rewrite", bus_write_enable, 1'b0);
            chk1("abort_no_ready", dma_ready, 1'b0);
        end

        // Randomized traffic; requesters drop on the edge after seeing ready
        cpu_busy = 0; dma_busy = 0; cpu_wait = 0; dma_wait = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cs = cpu_ready;
            ds = dma_ready;
            @(posedge clk);
            #1;
            if (reset) begin cpu_busy = 0; dma_busy = 0; end
            reset = ($urandom_range(0, 399) == 0);
            if (cs) cpu_busy = 0;
            if (ds) dma_busy = 0;
            if (!cpu_busy && $urandom_range(0, 3) == 0) begin
                cpu_busy = 1; cpu_wait = 0;
                cpu_write = 1'($urandom); cpu_address = 16'($urandom); cpu_wdata = 16'($urandom);
            end
            if (!dma_busy && $urandom_range(0, 3) == 0) begin
                dma_busy = 1; dma_wait = 0;
                dma_write = 1'($urandom); dma_address = 16'($urandom); dma_wdata = 16'($urandom);
            end
            if (cpu_busy) begin
                cpu_wait++;
                if (cpu_wait > 200) begin
                    checks++; errors++;
                    $display("FAIL cpu_timeout actual=no ready after %0d cycles required=ready", cpu_wait);
                    cpu_busy = 0;
                end
            end
            if (dma_busy) begin
                dma_wait++;
                if (dma_wait > 200) begin
                    checks++; errors++;
                    $display("FAIL dma_timeout actual=no ready after %0d cycles required=ready", dma_wait);
                    dma_busy = 0;
                end
            end
            cpu_request = cpu_busy;
            dma_request = dma_busy;
            bus_rdata = 16'($urandom);
        end

        reset = 0; cpu_request = 0; dma_request = 0;
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter placed in front of `memory_bus`. It lets the F100-L core and a DMA/loader engine share the single address/data/enable port of the four memory banks. Each access is a registered three-phase transaction (IDLE, ACCESS, RESPOND) with a `ready` handshake, so requesters stall until their data has been returned. Writes to the ROM bank are blocked and flagged.

## Interface
- `ADDR_WIDTH`, 16, address width on all ports
- `DATA_WIDTH`, 16, data width on all ports

Clocking and reset: one clock; reset is synchronous and active-high.

- `clk`  in  1  system clock; all state changes on its rising edge
- `reset`  in  1  synchronous, active-high
- `cpu_request`  in  1  CPU access request; held high until `cpu_ready`
- `cpu_write`  in  1  1 = write, 0 = read; stable while requesting
- `cpu_address`  in  ADDR_WIDTH  CPU address
- `cpu_wdata`  in  DATA_WIDTH  CPU write data
- `cpu_rdata`  out  DATA_WIDTH  CPU read data; valid while `cpu_ready` = 1
- `cpu_ready`  out  1  one-cycle transaction-complete pulse
- `dma_request`, `dma_write`, `dma_address`, `dma_wdata`, `dma_rdata`, `dma_ready`: same meaning for the DMA requester
- `rom_write_error`  out  1  one-cycle pulse in RESPOND when a write to bank 01 was dropped
- `bus_address`  out  ADDR_WIDTH  to `memory_bus` address
- `bus_wdata`  out  DATA_WIDTH  to `memory_bus` data_in
- `bus_rdata`  in  DATA_WIDTH  from `memory_bus` data_out
- `bus_enable`  out  1  to `memory_bus` bus_enable
- `bus_write_enable`  out  1  to `memory_bus` write_enable

## Operation
- States:
  - **IDLE**: bus outputs are held; `bus_enable` = 0.
  - **ACCESS**: the granted requester's address and data are registered onto the bus; `bus_enable` = 1.
  - **RESPOND**: read data is captured into the granted `*_rdata`; `*_ready` = 1.
- Transitions:
  - IDLE → ACCESS when any request is high at the clock edge. The grant is decided at that same edge.
  - ACCESS → RESPOND unconditionally.
  - RESPOND → IDLE unconditionally.
- Selection: when only one requester is asking, it is granted. When both ask, the priority rule in Configuration decides.
- `bus_write_enable` = 1 only in ACCESS, only for a write, and only when `address[14:13]` != 2'b01.
- ROM write (bank 01, write = 1):
  - The bus cycle still runs, with `bus_write_enable` = 0.
  - The requester still receives `ready`.
  - `rom_write_error` pulses in RESPOND.
- Read data: `bus_rdata` is sampled at the end of ACCESS into `*_rdata` of the granted side only. The other side's `*_rdata` holds its previous value.
- A request still high in the IDLE cycle after RESPOND is treated as a new transaction. Requesters must drop `request` on the edge where they see `ready`.
- The non-granted requester waits with its request held. It is never dropped.

## Timing
- Reset values: all outputs 0; state = IDLE; `last_grant` = DMA, so the CPU wins the first contested round.
- Request first seen high at edge N:
  - bus driven in cycle N+1 (ACCESS);
  - `ready` and `rdata` valid in cycle N+2 (RESPOND);
  - IDLE in cycle N+3.
- Latency is 2 cycles; throughput is at most one transaction per 3 cycles.
- Simultaneous requests: exactly one grant. The loser is granted in the next IDLE → ACCESS transition (3 cycles later) if it is still requesting.
- Requests that change during ACCESS or RESPOND are ignored. The registered address, data and write are used.
- Reset in any state forces IDLE on the next edge:
  - `bus_enable`, `bus_write_enable`, both `ready` and `rom_write_error` go low;
  - a write in flight in ACCESS is terminated after that single cycle and not repeated.

## Configuration
- `MEMORY_ARBITER_ROUND_ROBIN_EN` defined: on a contested request the grant goes to the side not in `last_grant`. `last_grant` updates on every grant.
- Not defined: fixed priority, CPU always wins contested requests. `last_grant` is still tracked but not used. DMA can be starved while the CPU requests continuously.

## Structure
- Shared package `memory_arbiter_pkg`:
  - state encoding (IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2);
  - grant encoding (GRANT_CPU = 1'b0, GRANT_DMA = 1'b1);
  - bank constants (BANK_RAM = 2'b00, BANK_ROM = 2'b01, BANK_PERIPH = 2'b10, BANK_BRAM = 2'b11).
- One combinational sub-module, `arbiter_pick`: inputs `cpu_request`, `dma_request`, `last_grant`; outputs `grant`, `any`. It contains the macro-dependent priority logic.

## Test plan
- CPU read 0x0004 alone, `bus_rdata` = 0x1234 in ACCESS → `bus_enable` high 1 cycle; `cpu_ready` and `cpu_rdata` = 0x1234 two cycles after the request edge; `dma_ready` stays 0.
- DMA write 0x6002 ← 0xBEEF → `bus_write_enable` high exactly 1 cycle with `bus_address` = 0x6002 and `bus_wdata` = 0xBEEF; `dma_ready` follows one cycle later.
- CPU write to 0x2010 (ROM) → `bus_write_enable` stays 0; `rom_write_error` and `cpu_ready` pulse together.
- Both request continuously for 4 transactions:
  - with the macro: grants go CPU, DMA, CPU, DMA;
  - without it: CPU, CPU, CPU, CPU and `dma_ready` never asserts.
- Reset asserted during ACCESS of a write → next cycle all outputs 0, state IDLE; no second write strobe; no `ready` pulse for the aborted access.
